// File: rtl/rvfi_commit_sequencer_if.sv
// Commit-trace bundle: multi-lane retire side in, single-lane trace side out.
// The sequencer uses the slave modport; whoever drives retire/consumes trace uses master.
interface rvfi_commit_sequencer_if #(
    parameter int unsigned LANES = 8
);
    logic [LANES-1:0]    in_valid;
    logic [LANES*32-1:0] in_inst;
    logic [LANES*32-1:0] in_pc_rdata;
    logic [LANES*32-1:0] in_pc_wdata;
    logic [LANES*5-1:0]  in_rd_addr;
    logic [LANES*32-1:0] in_rd_wdata;
    logic                in_ready;

    logic                out_valid;
    logic                out_ready;
    logic [63:0]         out_order;
    logic [31:0]         out_inst;
    logic [31:0]         out_pc_rdata;
    logic [31:0]         out_pc_wdata;
    logic [4:0]          out_rd_addr;
    logic [31:0]         out_rd_wdata;

    logic                halted;
    logic                done;

    modport master (
        output in_valid, in_inst, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata,
        output out_ready,
        input  in_ready, out_valid, out_order, out_inst, out_pc_rdata, out_pc_wdata,
        input  out_rd_addr, out_rd_wdata, halted, done
    );

    modport slave (
        input  in_valid, in_inst, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata,
        input  out_ready,
        output in_ready, out_valid, out_order, out_inst, out_pc_rdata, out_pc_wdata,
        output out_rd_addr, out_rd_wdata, halted, done
    );
endinterface

// File: rtl/rvfi_commit_sequencer.sv
// Compacts up to LANES retired instructions per cycle into an order-stamped FIFO and
// drains it one packet per cycle; stops accepting after the first halt instruction.
module rvfi_commit_sequencer #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DEPTH = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    rvfi_commit_sequencer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(LANES) + 1;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   order_cnt_q;
    logic          halted_q;

    logic [63:0] order_mem    [DEPTH];
    logic [31:0] inst_mem     [DEPTH];
    logic [31:0] pc_rdata_mem [DEPTH];
    logic [31:0] pc_wdata_mem [DEPTH];
    logic [4:0]  rd_addr_mem  [DEPTH];
    logic [31:0] rd_wdata_mem [DEPTH];

    logic             accept, pop, out_valid, halt_hit, stop;
    logic [SW-1:0]    slot;
    logic [LANES-1:0] lane_halt, lane_we;
    logic [PW-1:0]    lane_idx   [LANES];
    logic [63:0]      lane_order [LANES];

    assign bus.in_ready = !halted_q && (count_q <= CW'(DEPTH - LANES));
    assign accept       = bus.in_ready && (|bus.in_valid);
    assign out_valid    = (count_q != '0);
    assign pop          = out_valid && bus.out_ready;

    always_comb begin
        lane_halt = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_halt[i] = (bus.in_pc_rdata[i*32 +: 32] == bus.in_pc_wdata[i*32 +: 32]) ||
                           (bus.in_inst[i*32 +: 32] == 32'h0000_0063) ||
                           (bus.in_inst[i*32 +: 32] == 32'h0000_006F) ||
                           (bus.in_inst[i*32 +: 32] == 32'hF000_2013);
        end
    end

    // Valid lanes take consecutive slots; the first halt lane closes the cycle.
    always_comb begin
        slot     = '0;
        stop     = 1'b0;
        halt_hit = 1'b0;
        lane_we  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_idx[i]   = wr_ptr_q + PW'(slot);
            lane_order[i] = order_cnt_q + 64'(slot);
            if (accept && bus.in_valid[i] && !stop) begin
                lane_we[i] = 1'b1;
                slot       = slot + SW'(1);
                if (lane_halt[i]) begin
                    stop     = 1'b1;
                    halt_hit = 1'b1;
                end
            end
        end
    end

    assign count_d = count_q + CW'(slot) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            order_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + PW'(slot);
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
            count_q     <= count_d;
            order_cnt_q <= order_cnt_q + 64'(slot);
            if (halt_hit) begin
                halted_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                order_mem[lane_idx[i]]    <= lane_order[i];
                inst_mem[lane_idx[i]]     <= bus.in_inst[i*32 +: 32];
                pc_rdata_mem[lane_idx[i]] <= bus.in_pc_rdata[i*32 +: 32];
                pc_wdata_mem[lane_idx[i]] <= bus.in_pc_wdata[i*32 +: 32];
                rd_addr_mem[lane_idx[i]]  <= bus.in_rd_addr[i*5 +: 5];
                rd_wdata_mem[lane_idx[i]] <= (bus.in_rd_addr[i*5 +: 5] == 5'd0) ?
                                             32'd0 : bus.in_rd_wdata[i*32 +: 32];
            end
        end
    end

    // Data is zeroed while empty so storage needs no reset.
    assign bus.out_valid    = out_valid;
    assign bus.out_order    = out_valid ? order_mem[rd_ptr_q]    : 64'd0;
    assign bus.out_inst     = out_valid ? inst_mem[rd_ptr_q]     : 32'd0;
    assign bus.out_pc_rdata = out_valid ? pc_rdata_mem[rd_ptr_q] : 32'd0;
    assign bus.out_pc_wdata = out_valid ? pc_wdata_mem[rd_ptr_q] : 32'd0;
    assign bus.out_rd_addr  = out_valid ? rd_addr_mem[rd_ptr_q]  : 5'd0;
    assign bus.out_rd_wdata = out_valid ? rd_wdata_mem[rd_ptr_q] : 32'd0;

    assign bus.halted = halted_q;
    assign bus.done   = halted_q && (count_q == '0);
endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Directed bench for rvfi_commit_sequencer: vector table plus hand-written sequences
// for back-pressure drain, halt, and asynchronous reset.
module tb_rvfi_commit_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rvfi_commit_sequencer_if #(.LANES(8)) bus ();

    rvfi_commit_sequencer #(.LANES(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  valid;
        logic        ready;
        logic        e_in_ready;
        logic        e_valid;
        logic [63:0] e_order;
        int          e_tag;
        int          e_lane;
        logic        e_halted;
        logic        e_done;
    } vec_t;

    function automatic logic [31:0] pcv(input int tag, input int lane);
        return 32'h1000_0000 | (32'(tag) << 8) | (32'(lane) << 2);
    endfunction

    function automatic logic [31:0] wdv(input int lane);
        return (lane == 0) ? 32'd0 : (32'hDEAD_BE00 | 32'(lane));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every lane carries a NOP; lane 0 writes x0 so its data must be masked.
    task automatic drive(input logic [7:0] valid, input int tag, input logic ready);
        bus.in_valid  = valid;
        bus.out_ready = ready;
        for (int l = 0; l < 8; l++) begin
            bus.in_inst[l*32 +: 32]     = 32'h0000_0013;
            bus.in_pc_rdata[l*32 +: 32] = pcv(tag, l);
            bus.in_pc_wdata[l*32 +: 32] = pcv(tag, l) + 32'd4;
            bus.in_rd_addr[l*5 +: 5]    = 5'(l);
            bus.in_rd_wdata[l*32 +: 32] = 32'hDEAD_BE00 | 32'(l);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(8'h00, 0, 1'b0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic chk_head(input string name, input logic [63:0] order, input int tag,
                            input int lane);
        chk({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, " out_order"}, bus.out_order, order);
        chk({name, " out_pc_rdata"}, 64'(bus.out_pc_rdata), 64'(pcv(tag, lane)));
    endtask

    vec_t vecs[11];
    int   m_cnt;
    logic m_ir;
    longint m_head;

    initial begin
        // valid  rdy  in_rdy vld order tag lane halted done
        vecs[0]  = '{8'h01, 1, 1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{8'h00, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{8'hA5, 1, 1, 1, 1, 2, 0, 0, 0};
        vecs[3]  = '{8'h00, 1, 1, 1, 2, 2, 2, 0, 0};
        vecs[4]  = '{8'h00, 1, 1, 1, 3, 2, 5, 0, 0};
        vecs[5]  = '{8'h00, 1, 1, 1, 4, 2, 7, 0, 0};
        vecs[6]  = '{8'h01, 1, 1, 1, 5, 6, 0, 0, 0};
        vecs[7]  = '{8'h00, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{8'hFF, 0, 1, 1, 6, 8, 0, 0, 0};
        vecs[9]  = '{8'hFF, 0, 0, 1, 6, 8, 0, 0, 0};
        vecs[10] = '{8'hFF, 0, 0, 1, 6, 8, 0, 0, 0};

        drive(8'h00, 0, 1'b0);
        #12;
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_order", bus.out_order, 64'd0);
        chk("reset out_pc_rdata", 64'(bus.out_pc_rdata), 64'd0);
        chk("reset halted", 64'(bus.halted), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);

        for (int r = 0; r < 11; r++) begin
            drive(vecs[r].valid, r, vecs[r].ready);
            tick();
            chk($sformatf("row%0d in_ready", r), 64'(bus.in_ready), 64'(vecs[r].e_in_ready));
            chk($sformatf("row%0d out_valid", r), 64'(bus.out_valid), 64'(vecs[r].e_valid));
            chk($sformatf("row%0d halted", r), 64'(bus.halted), 64'(vecs[r].e_halted));
            chk($sformatf("row%0d done", r), 64'(bus.done), 64'(vecs[r].e_done));
            if (vecs[r].e_valid) begin
                chk($sformatf("row%0d out_order", r), bus.out_order, vecs[r].e_order);
                chk($sformatf("row%0d out_pc_rdata", r), 64'(bus.out_pc_rdata),
                    64'(pcv(vecs[r].e_tag, vecs[r].e_lane)));
                chk($sformatf("row%0d out_rd_wdata", r), 64'(bus.out_rd_wdata),
                    64'(wdv(vecs[r].e_lane)));
            end
        end

        // Drain under full-lane pressure; orders must stay contiguous from 6.
        m_cnt  = 16;
        m_ir   = 1'b0;
        m_head = 6;
        for (int c = 0; c < 60; c++) begin
            logic pop;
            if (c < 20) drive(8'hFF, 100 + c, 1'b1);
            else drive(8'h00, 100 + c, 1'b1);
            pop = (m_cnt > 0);
            if (m_ir && c < 20) m_cnt += 8;
            if (pop) begin
                m_cnt--;
                m_head++;
            end
            m_ir = (m_cnt <= 8);
            tick();
            chk($sformatf("drain%0d in_ready", c), 64'(bus.in_ready), 64'(m_ir));
            chk($sformatf("drain%0d out_valid", c), 64'(bus.out_valid), 64'(m_cnt > 0));
            if (m_cnt > 0) chk($sformatf("drain%0d out_order", c), bus.out_order, 64'(m_head));
            if (m_cnt == 0 && c >= 20) break;
        end

        // Halt on lane 3 via jal-self; lanes 4..7 must be discarded.
        do_reset();
        drive(8'hFF, 50, 1'b0);
        bus.in_inst[3*32 +: 32] = 32'h0000_006F;
        tick();
        chk("halt halted", 64'(bus.halted), 64'd1);
        chk("halt in_ready", 64'(bus.in_ready), 64'd0);
        chk("halt done early", 64'(bus.done), 64'd0);
        chk_head("halt head0", 64'd0, 50, 0);
        for (int k = 0; k < 4; k++) begin
            drive(8'hFF, 51, 1'b1);
            tick();
            chk($sformatf("halt pop%0d in_ready", k), 64'(bus.in_ready), 64'd0);
            if (k < 3) begin
                chk_head($sformatf("halt pop%0d", k), 64'(k + 1), 50, k + 1);
                chk($sformatf("halt pop%0d done", k), 64'(bus.done), 64'd0);
            end else begin
                chk("halt final out_valid", 64'(bus.out_valid), 64'd0);
                chk("halt final done", 64'(bus.done), 64'd1);
            end
        end

        // Halt via pc_rdata==pc_wdata accepted alongside a pop.
        do_reset();
        drive(8'h01, 60, 1'b1);
        tick();
        chk_head("halt2 first", 64'd0, 60, 0);
        drive(8'h02, 61, 1'b1);
        bus.in_pc_wdata[1*32 +: 32] = pcv(61, 1);
        tick();
        chk("halt2 halted", 64'(bus.halted), 64'd1);
        chk("halt2 done early", 64'(bus.done), 64'd0);
        chk_head("halt2 head", 64'd1, 61, 1);
        chk("halt2 rd_wdata", 64'(bus.out_rd_wdata), 64'h0000_0000_DEAD_BE01);
        drive(8'h00, 62, 1'b1);
        tick();
        chk("halt2 out_valid", 64'(bus.out_valid), 64'd0);
        chk("halt2 done", 64'(bus.done), 64'd1);

        // Asynchronous reset with six entries buffered.
        do_reset();
        drive(8'h3F, 70, 1'b0);
        tick();
        chk_head("rst pre", 64'd0, 70, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst async in_ready", 64'(bus.in_ready), 64'd1);
        #2;
        rst_n = 1'b1;
        drive(8'h01, 71, 1'b0);
        tick();
        chk_head("rst post", 64'd0, 71, 0);
        drive(8'h00, 72, 1'b1);
        tick();
        chk("rst post empty", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rvfi_commit_sequencer.md
# rvfi_commit_sequencer

Sequences the core's multi-lane commit stream into a single in-order trace stream. Each cycle it accepts up to `LANES` commit packets from the retire stage, stamps each with a 64-bit retirement order number, and buffers them in a FIFO. It drains the FIFO one packet per cycle to a single-channel trace consumer (the commit-log writer or a co-simulation port) under valid/ready handshake, and back-pressures retire when space runs short. It sits between the ROB retire lanes and the trace/log infrastructure. It also detects the program halt condition and closes the stream cleanly.

## Interface
- `LANES`, 8, commit lanes presented per cycle (power of two, 1..8)
- `DEPTH`, 16, FIFO entries (power of two, >= 2*LANES)
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `in_valid` in LANES: per-lane commit valid, any bit pattern legal (sparse allowed)
- `in_inst` in LANES*32: instruction word per lane
- `in_pc_rdata` in LANES*32: PC of the instruction per lane
- `in_pc_wdata` in LANES*32: next PC per lane
- `in_rd_addr` in LANES*5: destination register per lane
- `in_rd_wdata` in LANES*32: destination write data per lane
- `in_ready` out 1: retire may present lanes this cycle
- `out_valid` out 1: head packet available
- `out_ready` in 1: consumer takes the head packet
- `out_order` out 64: retirement order of the head packet
- `out_inst`, `out_pc_rdata`, `out_pc_wdata`, `out_rd_wdata` out 32 each: head packet fields
- `out_rd_addr` out 5: head packet destination register
- `halted` out 1: halt packet accepted, no further input taken
- `done` out 1: halted and FIFO fully drained

## Operation
- Accept condition: `in_ready && |in_valid`. The block ignores `in_valid` when `in_ready`=0. Retire must hold its lanes.
- `in_ready` = `!halted && (free_entries >= LANES)`, computed from registered state only.
- Compaction: valid lanes are written to consecutive FIFO slots in ascending lane index. Invalid lanes take no slot.
- Order stamping: the k-th accepted valid lane in a cycle gets `order_cnt + k`. At the end of the cycle, `order_cnt` advances by the number of lanes written. `order_cnt` resets to 0 and is 64-bit, wrapping modulo 2^64.
- `rd_wdata` is forced to 0 in the stored packet when `rd_addr`==0.
- Halt detection applies per lane. A lane is a halt lane when `pc_rdata==pc_wdata`, or `inst` is one of 0x00000063, 0x0000006F or 0xF0002013.
- On the lowest-indexed valid halt lane:
  - that lane is stored;
  - all higher-indexed lanes in the same cycle are discarded and not counted;
  - `halted` is set.
- `halted` is sticky until reset.
- Draining: `out_valid` = FIFO non-empty. A pop occurs on `out_valid && out_ready`. The `out_*` signals reflect the head entry combinationally from FIFO storage. They hold steady while `out_valid && !out_ready`.
- `done` = `halted && empty`.
- Count arithmetic:
  - `count_next = count + pushes - pop`, where pushes ranges 0..LANES and pop is 0..1.
  - The count register is `$clog2(DEPTH)+1` bits wide.
  - Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, all `out_*` data 0, `halted`=0, `done`=0, `order_cnt`=0, FIFO empty.
- Latency: a packet accepted at edge t appears on `out_*` with `out_valid`=1 after edge t. There is no bypass of an empty FIFO.
- Push and pop in the same cycle are legal. A pop from an entry frees it for the `in_ready` evaluation of the next cycle, not the current one.
- Full boundary: with count = DEPTH-LANES+1, `in_ready`=0 even if a pop is occurring.
- Empty boundary: `out_valid` drops the cycle after the last pop.
- A halt lane accepted together with a pop: `halted` rises after that edge, and `done` rises after the pop that empties the FIFO.
- Asynchronous reset mid-operation clears FIFO, counters and flags immediately. Buffered packets are lost, and `out_valid` drops without a handshake.

## Test plan
- Single lane: after reset, present `in_valid`=0x01, inst=0x00000013, pc 0x1000 -> 0x1004, with `out_ready`=1.
  - One cycle later: `out_valid`=1, `out_order`=0, `out_pc_rdata`=0x1000.
  - Next cycle: `out_valid`=0.
- Sparse compaction: present `in_valid`=0xA5 (lanes 0, 2, 5, 7) with `out_ready`=1.
  - Outputs emerge in lane order 0, 2, 5, 7 with orders 0, 1, 2, 3 on 4 consecutive cycles.
  - A following `in_valid`=0x01 gets order 4.
- Back-pressure: hold `out_ready`=0 and present 0xFF each cycle.
  - Two accepts fill 16 entries, then `in_ready`=0.
  - Raise `out_ready`. `in_ready` returns only once count <= 8; verify no packet is lost or duplicated (orders 0..N contiguous).
- Halt: present 0xFF with lane 3 carrying inst 0x0000006F.
  - Exactly lanes 0..3 are output (orders 0..3).
  - `halted`=1 after the edge, and `in_ready` stays 0.
  - `done`=1 the cycle after the 4th pop.
- `rd_wdata` masking: a lane with `rd_addr`=0 and `rd_wdata`=0xDEADBEEF -> `out_rd_wdata`=0.
- Reset mid-drain: with 6 entries buffered, assert `rst_n`=0 asynchronously.
  - `out_valid`=0 immediately.
  - After release, the next accepted lane has `out_order`=0.
